exp_norm_arbiter: RTL and testbench

Round-robin scheduler that shares a single `exp_normalizer` datapath between `NUM_REQ` GEMM row units. Each requester presents a group of four exponents with a valid/ready handshake. The block grants one requester per cycle, runs the group through the normalizer, and registers the result (max exponent, four offsets, requester ID) into a one-entry output stage with its own valid/ready handshake. It sits between the row-unit exponent extractors and the mantissa alignment shifters.

---
 rtl/exp_norm_arbiter_if.sv | 29 ++
 rtl/exp_norm_arbiter.sv | 152 +++++++++++++++
 tb/tb_exp_norm_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/exp_norm_arbiter_if.sv
// Bundle between the GEMM row-unit exponent extractors and the shared normalizer.
// It carries the requester side and the result side of the arbiter.
interface exp_norm_arbiter_if #(
  parameter int expWidth = 4,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A source holds valid and its data stable until it sees ready.
  // Ready may depend on valid; valid never depends on ready.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*expWidth*4-1:0] req_exp;
  logic                          out_valid;
  logic                          out_ready;
  logic [ID_W-1:0]               out_id;
  logic [expWidth-1:0]           max_exp;
  logic [expWidth*4-1:0]         exp_offset_num;

  modport master (
    output req_valid, req_exp, out_ready,
    input  req_ready, out_valid, out_id, max_exp, exp_offset_num
  );

  modport slave (
    input  req_valid, req_exp, out_ready,
    output req_ready, out_valid, out_id, max_exp, exp_offset_num
  );
endinterface

// File: rtl/exp_norm_arbiter.sv
// Round-robin arbiter sharing one four-lane exponent normalizer between
// NUM_REQ row units, with a one-entry registered result stage.

module exp_normalizer #(
  parameter int expWidth = 4
) (
  input  logic [4*expWidth-1:0] exp_in,
  output logic [expWidth-1:0]   max_exp,
  output logic [4*expWidth-1:0] exp_offset_num
);
  logic [expWidth-1:0] max01;
  logic [expWidth-1:0] max23;

  always_comb begin
    max01 = (exp_in[0*expWidth +: expWidth] > exp_in[1*expWidth +: expWidth]) ?
            exp_in[0*expWidth +: expWidth] : exp_in[1*expWidth +: expWidth];
    max23 = (exp_in[2*expWidth +: expWidth] > exp_in[3*expWidth +: expWidth]) ?
            exp_in[2*expWidth +: expWidth] : exp_in[3*expWidth +: expWidth];
    max_exp = (max01 > max23) ? max01 : max23;
    exp_offset_num = '0;
    // max_exp dominates every lane, so the subtraction never wraps.
    for (int i = 0; i < 4; i++) begin
      exp_offset_num[i*expWidth +: expWidth] = max_exp - exp_in[i*expWidth +: expWidth];
    end
  end
endmodule

module exp_norm_arbiter #(
  parameter int expWidth = 4,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  exp_norm_arbiter_if.slave   bus,
  output logic                dbg_state
);
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [expWidth-1:0]   max_exp_q, max_exp_d;
  logic [4*expWidth-1:0] offset_q, offset_d;

  logic                  accept_en;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W:0]         cand;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  transfer;
  logic [4*expWidth-1:0] grp_exp;
  logic [expWidth-1:0]   norm_max;
  logic [4*expWidth-1:0] norm_offset;

  assign accept_en = (state_q == ST_EMPTY) || bus.out_ready;

  // Rotating priority scan starting at ptr_q; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign transfer = !rst && accept_en && grant_found;

  always_comb begin
    req_ready_c = '0;
    if (transfer) begin
      req_ready_c[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grp_exp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grp_exp = bus.req_exp[i*4*expWidth +: 4*expWidth];
      end
    end
  end

  exp_normalizer #(.expWidth(expWidth)) u_norm (
    .exp_in         (grp_exp),
    .max_exp        (norm_max),
    .exp_offset_num (norm_offset)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_id_d  = out_id_q;
    max_exp_d = max_exp_q;
    offset_d  = offset_q;
    case (state_q)
      ST_EMPTY: begin
        if (transfer) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (transfer)          state_d = ST_FULL;
        else if (bus.out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (transfer) begin
      ptr_d     = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      out_id_d  = grant_idx;
      max_exp_d = norm_max;
      offset_d  = norm_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      out_id_q  <= '0;
      max_exp_q <= '0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_id_q  <= out_id_d;
      max_exp_q <= max_exp_d;
      offset_q  <= offset_d;
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.out_valid      = (state_q == ST_FULL);
  assign bus.out_id         = out_id_q;
  assign bus.max_exp        = max_exp_q;
  assign bus.exp_offset_num = offset_q;
  assign dbg_state          = state_q;

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready_c));
  a_no_grant_when_blocked: assert property (@(posedge clk)
    (state_q == ST_FULL && !bus.out_ready) |-> (req_ready_c == '0));
endmodule

// File: tb/tb_exp_norm_arbiter.sv
// Directed bench for exp_norm_arbiter: a spec-level model checked every
// cycle plus hand-computed literal expectations.
module tb_exp_norm_arbiter;
  localparam int EW = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk;
  logic rst;
  logic dbg_state;

  exp_norm_arbiter_if #(.expWidth(EW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  exp_norm_arbiter #(.expWidth(EW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] exp_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr;
  bit           m_valid;
  int           m_id;
  int           m_max;
  int           m_off[4];
  bit           cmp_en = 1'b0;

  function automatic int m_grant(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [4*EW-1:0] m_off_packed();
    logic [4*EW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*EW +: EW] = EW'(m_off[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    int lane[4];
    g = m_grant(bus.req_valid, m_ptr);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_max = 0;
      for (int i = 0; i < 4; i++) m_off[i] = 0;
    end else if ((!m_valid || bus.out_ready) && g >= 0) begin
      for (int i = 0; i < 4; i++) lane[i] = int'(bus.req_exp[g*4*EW + i*EW +: EW]);
      m_max = 0;
      for (int i = 0; i < 4; i++) if (lane[i] > m_max) m_max = lane[i];
      for (int i = 0; i < 4; i++) m_off[i] = m_max - lane[i];
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NR;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    cmp_en = 1'b1;
  end

  // Compare process: DUT outputs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NR-1:0] exp_ready;
      int g;
      exp_ready = '0;
      g = m_grant(bus.req_valid, m_ptr);
      if (!rst && (!m_valid || bus.out_ready) && g >= 0) exp_ready[g] = 1'b1;
      check("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("m_out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("m_dbg_state", 64'(dbg_state), 64'(m_valid));
      check("m_out_id", 64'(bus.out_id), 64'(m_id));
      check("m_max_exp", 64'(bus.max_exp), 64'(m_max));
      check("m_offsets", 64'(bus.exp_offset_num), 64'(m_off_packed()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int r, input logic [4*EW-1:0] v);
    bus.req_exp[r*4*EW +: 4*EW] = v;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    bus.req_exp   = '0;
    set_slice(0, 16'h9A2C);
    set_slice(1, 16'h1573);
    set_slice(2, 16'h0F08);
    set_slice(3, 16'h4444);

    // Reset held with every requester valid.
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 64'(bus.req_ready), 64'h0);
      check("rst_valid", 64'(bus.out_valid), 64'h0);
      check("rst_max", 64'(bus.max_exp), 64'h0);
      check("rst_offs", 64'(bus.exp_offset_num), 64'h0);
      check("rst_id", 64'(bus.out_id), 64'h0);
    end
    step_drive();
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", 64'(bus.req_ready), 64'h1);
    step_drive();
    bus.req_valid = 4'h0;
    @(negedge clk);
    check("r0_id", 64'(bus.out_id), 64'h0);
    check("r0_max", 64'(bus.max_exp), 64'd12);
    check("r0_offs", 64'(bus.exp_offset_num), 64'h32A0);

    // Single request from requester 1: lanes {1,5,7,3}.
    step_drive();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'h2);
    check("single_empty", 64'(bus.out_valid), 64'h0);
    step_drive();
    bus.req_valid = 4'h0;
    @(negedge clk);
    check("single_valid", 64'(bus.out_valid), 64'h1);
    check("single_id", 64'(bus.out_id), 64'h1);
    check("single_max", 64'(bus.max_exp), 64'd7);
    check("single_offs", 64'(bus.exp_offset_num), 64'h6204);

    // Wrap ptr back to 0 via requester 3, then full round-robin.
    step_drive();
    bus.req_valid = 4'b1000;
    step_drive();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        exp_id = exp_q.pop_front();
        check("rr_id", 64'(bus.out_id), 64'(exp_id));
        check("rr_no_bubble", 64'(bus.out_valid), 64'h1);
      end
      exp_q.push_back(IW'(k % 4));
    end

    // Back-pressure with requesters 2 and 3 waiting.
    step_drive();
    bus.req_valid = 4'b1100;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == 0) begin
        exp_id = exp_q.pop_front();
        check("rr_last_id", 64'(bus.out_id), 64'(exp_id));
      end
      check("bp_ready", 64'(bus.req_ready), 64'h0);
      check("bp_valid", 64'(bus.out_valid), 64'h1);
      check("bp_id", 64'(bus.out_id), 64'h1);
      check("bp_offs", 64'(bus.exp_offset_num), 64'h6204);
    end
    step_drive();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(bus.req_ready), 64'h4);
    check("bp_still_full", 64'(bus.out_valid), 64'h1);

    // Pointer at 3 with only 0 and 3 valid: 3 first, then wrap to 0.
    step_drive();
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("skip_grant3", 64'(bus.req_ready), 64'h8);
    check("skip_id2", 64'(bus.out_id), 64'h2);
    step_drive();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("wrap_grant0", 64'(bus.req_ready), 64'h1);
    check("wrap_id3", 64'(bus.out_id), 64'h3);

    // Reset mid-stream while requesters 2 and 3 are pending.
    step_drive();
    bus.req_valid = 4'hF;
    step_drive();
    step_drive();
    rst = 1'b1;
    bus.req_valid = 4'b1100;
    set_slice(2, 16'hFFFF);
    @(negedge clk);
    check("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    step_drive();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(bus.out_valid), 64'h0);
    check("post_rst_grant", 64'(bus.req_ready), 64'h4);
    step_drive();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("all15_id", 64'(bus.out_id), 64'h2);
    check("all15_max", 64'(bus.max_exp), 64'd15);
    check("all15_offs", 64'(bus.exp_offset_num), 64'h0);
    check("pending3", 64'(bus.req_ready), 64'h8);
    step_drive();
    bus.req_valid = 4'h0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
